// File: rtl/mips_mc_pkg.sv
// Shared types and constants for the MIPS multi-cycle core.
package mips_mc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DRAIN
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR       = 32'h0000_0000;
    localparam int unsigned WORD_ALIGN_BITS = 2;

    // True when the low address bits select a whole word.
    function automatic logic word_aligned(input logic [WORD_ALIGN_BITS-1:0] lsb);
        return (lsb == '0);
    endfunction

endpackage

// File: rtl/instr_fetch_unit_sat_counter.sv
// Saturating up-counter; clr and inc together load a count of one.
module sat_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= inc ? WIDTH'(1) : '0;
        end else if (inc && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: req/ack handshake with instruction memory, IR latch,
// misalignment rejection and saturating fetch-latency report.
module instr_fetch_unit
    import mips_mc_pkg::*;
#(
    parameter int unsigned        ADDR_W   = 32,
    parameter int unsigned        DATA_W   = 32,
    parameter logic [DATA_W-1:0]  IR_RESET = DATA_W'(NOP_INSTR),
    parameter int unsigned        LAT_W    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_start,
    input  logic [ADDR_W-1:0] pc_in,
    input  logic              flush,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] ir_out,
    output logic              ir_valid,
    output logic              busy,
    output logic              fetch_err,
    output logic [LAT_W-1:0]  lat_cycles
);

    fetch_state_t     state;
    logic             aligned;
    logic             accept;
    logic             cnt_clr;
    logic             cnt_inc;
    logic [LAT_W-1:0] lat_count;

    always_comb begin
        aligned = word_aligned(pc_in[WORD_ALIGN_BITS-1:0]);
        accept  = (state == IDLE) && !flush && fetch_start && aligned;
        cnt_clr = accept;
        // The counter tracks the current cycle number of the request, so it
        // already holds the latency value in the cycle mem_ack arrives.
        cnt_inc = accept || ((state == REQ) && !mem_ack && !flush);
    end

    sat_counter #(
        .WIDTH(LAT_W)
    ) u_lat_counter (
        .clk  (clk),
        .rst  (rst),
        .clr  (cnt_clr),
        .inc  (cnt_inc),
        .count(lat_count)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            mem_req    <= 1'b0;
            mem_addr   <= '0;
            ir_out     <= IR_RESET;
            ir_valid   <= 1'b0;
            fetch_err  <= 1'b0;
            lat_cycles <= '0;
        end else begin
            ir_valid  <= 1'b0;
            fetch_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (!flush && fetch_start) begin
                        if (!aligned) begin
                            fetch_err <= 1'b1;
                        end else begin
                            mem_addr <= pc_in;
                            mem_req  <= 1'b1;
                            state    <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        state   <= IDLE;
                        if (!flush) begin
                            ir_out     <= mem_rdata;
                            ir_valid   <= 1'b1;
                            lat_cycles <= lat_count;
                        end
                    end else if (flush) begin
                        // A request may not be withdrawn; wait for the ack.
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: begin
                    mem_req <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule
